decode_imm_stage: RTL

IF/ID pipeline stage for the pipelined LEGv8 CPU. It sits between instruction fetch and register read/execute. It registers the fetched instruction and PC, classifies the immediate format from the opcode, and presents a 64-bit extended immediate alongside the instruction one cycle later. A two-entry skid buffer gives a valid/ready handshake, so downstream stalls never drop or duplicate an instruction. A flush input squashes everything in flight on a taken branch.

---
 rtl/decode_pkg.sv | 22 ++
 rtl/decode_imm_stage_imm_gen.sv | 50 +++++
 rtl/signExtend.sv | 12 +
 rtl/decode_imm_stage.sv | 85 ++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and opcode prefixes for the LEGv8 decode stage.
// Opcode constants are the leading bits each immediate format is keyed on.
package decode_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_D    = 3'd1,
        IMM_I    = 3'd2,
        IMM_CB   = 3'd3,
        IMM_B    = 3'd4
    } imm_type_e;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;

endpackage

// File: rtl/decode_imm_stage_imm_gen.sv
// Immediate classifier and extender for one LEGv8 instruction.
// Combinational, zero latency; no handshake.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [63:0] imm,
    output logic [2:0]  imm_type
);

    imm_type_e   kind;
    logic [63:0] imm_d;
    logic [63:0] imm_cb;
    logic [63:0] imm_b;
    logic [63:0] imm_i;

    signExtend #(.WIDTH(9))  u_sx_d  (.din(instr[20:12]), .dout(imm_d));
    signExtend #(.WIDTH(19)) u_sx_cb (.din(instr[23:5]),  .dout(imm_cb));
    signExtend #(.WIDTH(26)) u_sx_b  (.din(instr[25:0]),  .dout(imm_b));

    assign imm_i = {52'd0, instr[21:10]};

    // First matching prefix wins; branch offsets stay unshifted for execute.
    always_comb begin
        kind = IMM_NONE;
        if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
            kind = IMM_B;
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_BCOND) begin
            kind = IMM_CB;
        end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            kind = IMM_D;
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
            kind = IMM_I;
        end
    end

    always_comb begin
        imm = 64'd0;
        case (kind)
            IMM_D:   imm = imm_d;
            IMM_I:   imm = imm_i;
            IMM_CB:  imm = imm_cb;
            IMM_B:   imm = imm_b;
            default: imm = 64'd0;
        endcase
    end

    assign imm_type = kind;

endmodule

// File: rtl/signExtend.sv
// Sign-extends a WIDTH-bit field to 64 bits.
// Purely combinational, no handshake.
module signExtend #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] din,
    output logic [63:0]      dout
);

    assign dout = {{(64-WIDTH){din[WIDTH-1]}}, din};

endmodule

// File: rtl/decode_imm_stage.sv
// IF/ID register: captures instruction, PC and extended immediate.
// Latency 1 cycle; two-entry skid buffer, in_ready driven from registered state only.
module decode_imm_stage
    import decode_pkg::*;
#(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [63:0]        out_imm,
    output logic [2:0]         out_imm_type
);

    logic [63:0] gen_imm;
    logic [2:0]  gen_type;

    imm_gen u_imm_gen (
        .instr    (in_instr[31:0]),
        .imm      (gen_imm),
        .imm_type (gen_type)
    );

    logic               main_vld;
    logic               skid_vld;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;
    logic [63:0]        skid_imm;
    logic [2:0]         skid_type;

    logic accept;
    logic drain;

    assign in_ready  = ~skid_vld & ~reset;
    assign accept    = in_valid & in_ready;
    assign drain     = main_vld & out_ready;
    assign out_valid = main_vld;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_vld     <= 1'b0;
            skid_vld     <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_imm      <= '0;
            out_imm_type <= IMM_NONE;
            skid_instr   <= '0;
            skid_pc      <= '0;
            skid_imm     <= '0;
            skid_type    <= IMM_NONE;
        end else if (drain && skid_vld) begin
            // Skid always holds the younger entry, so it moves up behind main.
            main_vld     <= 1'b1;
            skid_vld     <= 1'b0;
            out_instr    <= skid_instr;
            out_pc       <= skid_pc;
            out_imm      <= skid_imm;
            out_imm_type <= skid_type;
        end else if (drain || !main_vld) begin
            main_vld <= accept;
            if (accept) begin
                out_instr    <= in_instr;
                out_pc       <= in_pc;
                out_imm      <= gen_imm;
                out_imm_type <= gen_type;
            end
        end else if (accept) begin
            skid_vld   <= 1'b1;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_imm   <= gen_imm;
            skid_type  <= gen_type;
        end
    end

endmodule
